pipelined_addsub: RTL and testbench

//  Parametrised, pipelined two's-complement add/subtract unit for the datapath.

---
 rtl/pipelined_addsub_pkg.sv | 11 +
 rtl/pipelined_addsub_if.sv | 29 ++
 rtl/pipelined_addsub_stage.sv | 81 ++++++++
 rtl/pipelined_addsub.sv | 88 ++++++++
 tb/tb_pipelined_addsub.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_addsub_pkg.sv
// Shared defaults and stage-count helper for the segmented add/subtract datapath.
package pipelined_addsub_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SEG_W_DEF = 4;

  function automatic int nstages(input int width, input int seg_w);
    return (seg_w < 1) ? 1 : width / seg_w;
  endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub; slave is the unit, master the caller.
interface pipelined_addsub_if #(
  parameter int WIDTH = pipelined_addsub_pkg::WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, sub, cin, a, b, out_ready,
    input  in_ready, out_valid, r, cout, ovf, zero
  );

  modport slave (
    input  in_valid, sub, cin, a, b, out_ready,
    output in_ready, out_valid, r, cout, ovf, zero
  );

endinterface

// File: rtl/pipelined_addsub_stage.sv
// One SEG_W-bit slice of the pipelined carry chain. The x vector holds the pending
// {a,b} segment pairs above the finished result slices; each stage shrinks it by SEG_W.
module addsub_stage
  import pipelined_addsub_pkg::*;
#(
  parameter int  WIDTH = WIDTH_DEF,
  parameter int  SEG_W = SEG_W_DEF,
  parameter int  IDX   = 0,
  localparam int XI    = 2*WIDTH - IDX*SEG_W,
  localparam int XO    = XI - SEG_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_i,
  input  logic          valid_i,
  input  logic          carry_i,
  input  logic          zero_i,
  input  logic          ovf_i,
  input  logic [XI-1:0] x_i,
  output logic          valid_o,
  output logic          carry_o,
  output logic          zero_o,
  output logic          ovf_o,
  output logic [XO-1:0] x_o
);

  localparam int            LO      = IDX*SEG_W;
  localparam bit            LAST    = (IDX == nstages(WIDTH, SEG_W) - 1);
  localparam logic [XI-1:0] LO_MASK = (XI'(1) << LO) - XI'(1);

  logic [SEG_W-1:0] a_seg, b_seg;
  logic [SEG_W:0]   sum;
  logic             msb_cin, seg_ovf, en;
  logic [XI-1:0]    upper_w, mid_w;

  logic          valid_q, valid_d;
  logic          carry_q, carry_d;
  logic          zero_q, zero_d;
  logic          ovf_q, ovf_d;
  logic [XO-1:0] x_q, x_d;

  always_comb begin
    b_seg   = x_i[LO +: SEG_W];
    a_seg   = x_i[LO+SEG_W +: SEG_W];
    sum     = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_W{1'b0}}, carry_i};
    // carry into the slice MSB recovered from the MSB sum bit
    msb_cin = a_seg[SEG_W-1] ^ b_seg[SEG_W-1] ^ sum[SEG_W-1];
    seg_ovf = LAST ? (msb_cin ^ sum[SEG_W]) : 1'b0;
    upper_w = (x_i >> (LO + 2*SEG_W)) << (LO + SEG_W);
    mid_w   = {{(XI-SEG_W){1'b0}}, sum[SEG_W-1:0]} << LO;
    en      = valid_i & ~stall_i;
    valid_d = stall_i ? valid_q : valid_i;
    carry_d = en ? sum[SEG_W] : carry_q;
    zero_d  = en ? (zero_i & ~|sum[SEG_W-1:0]) : zero_q;
    ovf_d   = en ? (ovf_i | seg_ovf) : ovf_q;
    x_d     = en ? XO'(upper_w | mid_w | (x_i & LO_MASK)) : x_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      x_q     <= '0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      x_q     <= x_d;
    end
  end

  assign valid_o = valid_q;
  assign carry_o = carry_q;
  assign zero_o  = zero_q;
  assign ovf_o   = ovf_q;
  assign x_o     = x_q;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/subtract: NSTAGES carry-chain segments, one result
// per clock, whole-pipe stall on output back-pressure.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEG_W = SEG_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  pipelined_addsub_if.slave  bus
);

  localparam int NSTAGES = nstages(WIDTH, SEG_W);

  if (SEG_W < 1) begin : g_bad_seg
    $error("pipelined_addsub: SEG_W must be >= 1");
  end else if (WIDTH % SEG_W != 0) begin : g_bad_width
    $error("pipelined_addsub: WIDTH must be a multiple of SEG_W");
  end

  logic               stall;
  logic [WIDTH-1:0]   b_eff;
  logic [2*WIDTH-1:0] x0;

  // interleave operands as {a_seg, b_seg} pairs, segment 0 lowest
  always_comb begin
    stall = bus.out_valid & ~bus.out_ready;
    b_eff = bus.sub ? ~bus.b : bus.b;
    x0    = '0;
    for (int j = 0; j < NSTAGES; j++) begin
      x0[2*j*SEG_W +: SEG_W]     = b_eff[j*SEG_W +: SEG_W];
      x0[(2*j+1)*SEG_W +: SEG_W] = bus.a[j*SEG_W +: SEG_W];
    end
  end

  assign bus.in_ready = ~stall;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    localparam int XI = 2*WIDTH - k*SEG_W;

    logic [XI-1:0]       x_in;
    logic [XI-SEG_W-1:0] x_out;
    logic                valid_in, carry_in, zero_in, ovf_in;
    logic                valid_out, carry_out, zero_out, ovf_out;

    if (k == 0) begin : g_head
      assign x_in     = x0;
      assign valid_in = bus.in_valid;
      assign carry_in = bus.cin;
      assign zero_in  = 1'b1;
      assign ovf_in   = 1'b0;
    end else begin : g_link
      assign x_in     = g_stage[k-1].x_out;
      assign valid_in = g_stage[k-1].valid_out;
      assign carry_in = g_stage[k-1].carry_out;
      assign zero_in  = g_stage[k-1].zero_out;
      assign ovf_in   = g_stage[k-1].ovf_out;
    end

    addsub_stage #(
      .WIDTH (WIDTH),
      .SEG_W (SEG_W),
      .IDX   (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .stall_i (stall),
      .valid_i (valid_in),
      .carry_i (carry_in),
      .zero_i  (zero_in),
      .ovf_i   (ovf_in),
      .x_i     (x_in),
      .valid_o (valid_out),
      .carry_o (carry_out),
      .zero_o  (zero_out),
      .ovf_o   (ovf_out),
      .x_o     (x_out)
    );
  end

  assign bus.out_valid = g_stage[NSTAGES-1].valid_out;
  assign bus.r         = g_stage[NSTAGES-1].x_out;
  assign bus.cout      = g_stage[NSTAGES-1].carry_out;
  assign bus.ovf       = g_stage[NSTAGES-1].ovf_out;
  assign bus.zero      = g_stage[NSTAGES-1].zero_out;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: 16/4 instance via a result queue, 32/8 instance spot check.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(16)) n_if ();
  pipelined_addsub_if #(.WIDTH(32)) w_if ();

  pipelined_addsub #(.WIDTH(16), .SEG_W(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (n_if)
  );

  pipelined_addsub #(.WIDTH(32), .SEG_W(8)) u_dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (w_if)
  );

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        v;
    logic        z;
    int          acc;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   chk_lat = 1'b1;
  exp_t exp_q[$];

  logic [15:0] ta [8] = '{16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0F0F, 16'h5555};
  logic [15:0] tb [8] = '{16'h4321, 16'h1111, 16'h0000, 16'hFFFF, 16'h8000, 16'h8000, 16'hF0F0, 16'hAAAA};
  logic        ts [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        tc [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] r, input logic c, input logic v, input logic z);
    exp_t e;
    e.r = r; e.c = c; e.v = v; e.z = z; e.acc = 0;
    return e;
  endfunction

  function automatic exp_t model(input logic sb, input logic ci, input logic [15:0] av, input logic [15:0] bv);
    logic [15:0] be;
    logic [16:0] s;
    be = sb ? ~bv : bv;
    s  = {1'b0, av} + {1'b0, be} + {16'h0000, ci};
    return mk(s[15:0], s[16], (av[15] == be[15]) && (s[15] != av[15]), s[15:0] == 16'h0000);
  endfunction

  // one cycle on the 16-bit unit, starting just after a falling edge
  task automatic step(input logic iv, input logic sb, input logic ci, input logic [15:0] av,
                      input logic [15:0] bv, input logic ordy, input exp_t e);
    exp_t f;
    n_if.out_ready = ordy;
    n_if.in_valid  = iv;
    n_if.sub       = sb;
    n_if.cin       = ci;
    n_if.a         = av;
    n_if.b         = bv;
    #1;
    if (n_if.out_valid && n_if.out_ready) begin
      chk_eq("retire_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        f = exp_q.pop_front();
        chk_eq("r", n_if.r, f.r);
        chk_eq("cout", n_if.cout, f.c);
        chk_eq("ovf", n_if.ovf, f.v);
        chk_eq("zero", n_if.zero, f.z);
        if (chk_lat) chk_eq("latency", cyc - f.acc, 4);
      end
    end
    if (n_if.in_valid && n_if.in_ready) begin
      f     = e;
      f.acc = cyc;
      exp_q.push_back(f);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input logic ordy, input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, ordy, mk(16'h0000, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n          = 1'b0;
    n_if.in_valid  = 1'b0; n_if.sub = 1'b0; n_if.cin = 1'b0;
    n_if.a         = '0;   n_if.b   = '0;   n_if.out_ready = 1'b1;
    w_if.in_valid  = 1'b0; w_if.sub = 1'b0; w_if.cin = 1'b0;
    w_if.a         = '0;   w_if.b   = '0;   w_if.out_ready = 1'b1;

    #12;
    chk_eq("rst_out_valid", n_if.out_valid, 1'b0);
    chk_eq("rst_r", n_if.r, 16'h0000);
    chk_eq("rst_cout", n_if.cout, 1'b0);
    chk_eq("rst_ovf", n_if.ovf, 1'b0);
    chk_eq("rst_zero", n_if.zero, 1'b0);
    chk_eq("rst_w_out_valid", w_if.out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_eq("rst_in_ready", n_if.in_ready, 1'b1);
    chk_eq("rst_w_in_ready", w_if.in_ready, 1'b1);

    // 32-bit / 8-bit segments: FFFFFFFF + 1
    @(negedge clk);
    w_if.in_valid = 1'b1;
    w_if.a        = 32'hFFFF_FFFF;
    w_if.b        = 32'h0000_0001;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      w_if.in_valid = 1'b0;
    end while (!w_if.out_valid && lat < 12);
    chk_eq("w_latency", lat, 4);
    chk_eq("w_r", w_if.r, 32'h0000_0000);
    chk_eq("w_cout", w_if.cout, 1'b1);
    chk_eq("w_ovf", w_if.ovf, 1'b0);
    chk_eq("w_zero", w_if.zero, 1'b1);
    @(negedge clk);
    chk_eq("w_single_result", w_if.out_valid, 1'b0);

    // hand-computed carry / overflow / borrow cases
    step(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1));
    step(1'b1, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 1'b1, mk(16'h8000, 1'b0, 1'b1, 1'b0));
    step(1'b1, 1'b1, 1'b1, 16'h0005, 16'h0007, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b0));
    step(1'b1, 1'b1, 1'b1, 16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b0));
    idle(1'b1, 6);
    chk_eq("drain_hand", exp_q.size(), 0);

    // back-to-back stream
    for (int i = 0; i < 8; i++)
      step(1'b1, ts[i], tc[i], ta[i], tb[i], 1'b1, model(ts[i], tc[i], ta[i], tb[i]));
    idle(1'b1, 6);
    chk_eq("drain_stream", exp_q.size(), 0);

    // back-pressure: three ops in, result held three cycles, new op waits
    chk_lat = 1'b0;
    step(1'b1, 1'b0, 1'b0, 16'h1111, 16'h2222, 1'b0, model(1'b0, 1'b0, 16'h1111, 16'h2222));
    step(1'b1, 1'b0, 1'b0, 16'h00FF, 16'h0001, 1'b0, model(1'b0, 1'b0, 16'h00FF, 16'h0001));
    step(1'b1, 1'b1, 1'b1, 16'h1000, 16'h0001, 1'b0, model(1'b1, 1'b1, 16'h1000, 16'h0001));
    idle(1'b0, 1);
    for (int i = 0; i < 3; i++) begin
      chk_eq("hold_out_valid", n_if.out_valid, 1'b1);
      chk_eq("hold_r", n_if.r, 16'h3333);
      chk_eq("hold_cout", n_if.cout, 1'b0);
      chk_eq("hold_in_ready", n_if.in_ready, 1'b0);
      step(1'b1, 1'b0, 1'b0, 16'h4444, 16'h0004, 1'b0, model(1'b0, 1'b0, 16'h4444, 16'h0004));
    end
    step(1'b1, 1'b0, 1'b0, 16'h4444, 16'h0004, 1'b1, model(1'b0, 1'b0, 16'h4444, 16'h0004));
    idle(1'b1, 8);
    chk_eq("drain_stall", exp_q.size(), 0);

    // reset with ops in flight
    chk_lat = 1'b1;
    step(1'b1, 1'b0, 1'b0, 16'h1234, 16'h1111, 1'b1, model(1'b0, 1'b0, 16'h1234, 16'h1111));
    step(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b1, model(1'b0, 1'b0, 16'hFFFF, 16'h0001));
    step(1'b1, 1'b1, 1'b1, 16'h0003, 16'h0009, 1'b1, model(1'b1, 1'b1, 16'h0003, 16'h0009));
    n_if.in_valid = 1'b0;
    #1;
    chk_eq("pre_rst_out_valid", n_if.out_valid, 1'b0);
    @(negedge clk);
    chk_eq("pre_rst_first_valid", n_if.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_out_valid", n_if.out_valid, 1'b0);
    chk_eq("mid_rst_r", n_if.r, 16'h0000);
    chk_eq("mid_rst_cout", n_if.cout, 1'b0);
    chk_eq("mid_rst_ovf", n_if.ovf, 1'b0);
    chk_eq("mid_rst_zero", n_if.zero, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1, 8);
    chk_eq("post_rst_out_valid", n_if.out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
